mem_access_unit: RTL and testbench

//  Load/store front end between the EX-stage ALU result and the data memory; feeds loadDataExt (fromMem) downstream.

---
 rtl/mem_access_unit_pkg.sv | 50 +++++
 rtl/store_lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store front end: bus width, funct3 encodings,
// FSM state encoding and the access-size decode used by alignment and lane logic.
package mem_access_unit_pkg;

   localparam int BUS_SIZE = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Unknown encodings fall back to a full word in either direction.
   function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
      size_e sz;
      sz = SZ_WORD;
      if (is_store) begin
         case (f3)
            F3_SB:   sz = SZ_BYTE;
            F3_SH:   sz = SZ_HALF;
            F3_SW:   sz = SZ_WORD;
            default: sz = SZ_WORD;
         endcase
      end else begin
         case (f3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            F3_LW:         sz = SZ_WORD;
            default:       sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane steering for stores plus the alignment check for
// every access size; loads always enable all four lanes.
module store_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]          funct3,
   input  logic                is_store,
   input  logic [1:0]          addr_lo,
   input  logic [BUS_SIZE-1:0] wd,
   output logic [BUS_SIZE-1:0] wdata,
   output logic [3:0]          byteen,
   output logic                misaligned
);

   size_e size;

   always_comb begin
      size       = access_size(funct3, is_store);
      wdata      = wd;
      byteen     = 4'b1111;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            if (is_store) begin
               wdata  = {4{wd[7:0]}};
               byteen = 4'b0001 << addr_lo;
            end
         end
         SZ_HALF: begin
            misaligned = addr_lo[0];
            if (is_store) begin
               wdata  = {2{wd[15:0]}};
               byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
         end
         default: begin
            misaligned = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: one req/ack memory transaction per CPU access, with
// CPU stall, store lane alignment, right-aligned load return and a bus timeout.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [BUS_SIZE-1:0] addr,
   input  logic [BUS_SIZE-1:0] writeData,
   input  logic [2:0]          funct3,
   input  logic                memRead,
   input  logic                memWrite,
   output logic                busywait,
   output logic [BUS_SIZE-1:0] fromMem,
   output logic                misaligned,
   output logic                bus_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [BUS_SIZE-1:0] mem_addr,
   output logic [BUS_SIZE-1:0] mem_wdata,
   output logic [3:0]          mem_byteen,
   input  logic [BUS_SIZE-1:0] mem_rdata,
   input  logic                mem_ack,
   output logic [1:0]          dbg_state
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [BUS_SIZE-1:0] addr_q, addr_d;
   logic                we_q, we_d;
   logic [BUS_SIZE-1:0] wdata_q, wdata_d;
   logic [3:0]          byteen_q, byteen_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BUS_SIZE-1:0] from_mem_q, from_mem_d;
   logic                bus_err_q, bus_err_d;

   logic                req_any;
   logic                req;
   logic                mis_raw;
   logic [BUS_SIZE-1:0] lane_wdata;
   logic [3:0]          lane_byteen;

   // A write wins when the CPU raises memRead and memWrite together.
   store_lane_align u_align (
      .funct3     (funct3),
      .is_store   (memWrite),
      .addr_lo    (addr[1:0]),
      .wd         (writeData),
      .wdata      (lane_wdata),
      .byteen     (lane_byteen),
      .misaligned (mis_raw)
   );

   assign req_any    = memRead | memWrite;
   assign req        = req_any & ~mis_raw;
   assign misaligned = (state_q == ST_IDLE) & req_any & mis_raw;

   // Memory handshake: mem_req stays high for the whole ACCESS state with all
   // mem_* fields stable; a single-cycle mem_ack completes it. Acks seen outside
   // ACCESS belong to an abandoned transaction and are ignored.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      byteen_d   = byteen_q;
      cnt_d      = cnt_q;
      from_mem_d = from_mem_q;
      bus_err_d  = bus_err_q;
      busywait   = 1'b0;
      mem_req    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busywait = req;
            if (req) begin
               addr_d   = addr;
               we_d     = memWrite;
               wdata_d  = lane_wdata;
               byteen_d = lane_byteen;
               cnt_d    = '0;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            busywait = 1'b1;
            mem_req  = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (mem_ack) begin
               if (!we_q) begin
                  from_mem_d = mem_rdata >> {addr_q[1:0], 3'b000};
               end
               state_d = ST_DONE;
            end else if (cnt_q == CNT_MAX) begin
               bus_err_d  = 1'b1;
               from_mem_d = '0;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            bus_err_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         byteen_q   <= '0;
         cnt_q      <= '0;
         from_mem_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         byteen_q   <= byteen_d;
         cnt_q      <= cnt_d;
         from_mem_q <= from_mem_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = {addr_q[BUS_SIZE-1:2], 2'b00};
   assign mem_wdata  = wdata_q;
   assign mem_byteen = byteen_q;
   assign fromMem    = from_mem_q;
   assign bus_err    = bus_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Transaction-level bench for mem_access_unit: directed scenarios followed by
// random loads/stores, each checked against a byte-lane reference model.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        CLK;
  logic        RESET;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [2:0]  funct3;
  logic        memRead;
  logic        memWrite;
  logic        busywait;
  logic [31:0] fromMem;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int checks;
  int errors;
  logic [31:0] model_from_mem;
  logic [31:0] exp_q[$];

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .addr       (addr),
    .writeData  (writeData),
    .funct3     (funct3),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .busywait   (busywait),
    .fromMem    (fromMem),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_size(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int sz);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % sz) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] model_byteen(input logic st, input int sz, input int off);
    logic [3:0] m;
    if (!st || sz == 4) return 4'hF;
    m = (sz == 1) ? 4'b0001 : 4'b0011;
    return m << off;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle(input logic stray_ack);
    next_cycle();
    memRead   = 1'b0;
    memWrite  = 1'b0;
    mem_ack   = stray_ack;
    mem_rdata = $urandom;
    #2;
    check("idle_busywait", {31'd0, busywait}, 32'd0);
    check("idle_mem_req", {31'd0, mem_req}, 32'd0);
    check("idle_bus_err", {31'd0, bus_err}, 32'd0);
    check("idle_state", {30'd0, dbg_state}, 32'd0);
    check("idle_fromMem_hold", fromMem, model_from_mem);
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdata);
    int sz, off, busy_cnt, req_cnt, exp_busy, exp_req;
    logic mis, timed_out, done;
    logic [31:0] exp_fm;
    sz        = model_size(wr, f3);
    off       = int'(a[1:0]);
    mis       = (off % sz) != 0;
    timed_out = (ack_at < 1) || (ack_at > TIMEOUT);

    next_cycle();
    memRead   = rd;
    memWrite  = wr;
    funct3    = f3;
    addr      = a;
    writeData = wd;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    #2;
    check("req_fromMem_hold", fromMem, model_from_mem);
    check("req_bus_err", {31'd0, bus_err}, 32'd0);
    check("req_mem_req", {31'd0, mem_req}, 32'd0);
    if (mis) begin
      check("mis_flag", {31'd0, misaligned}, 32'd1);
      check("mis_busywait", {31'd0, busywait}, 32'd0);
      next_cycle();
      #2;
      check("mis_no_req", {31'd0, mem_req}, 32'd0);
      check("mis_state", {30'd0, dbg_state}, 32'd0);
      check("mis_flag_held", {31'd0, misaligned}, 32'd1);
      return;
    end
    check("req_misaligned", {31'd0, misaligned}, 32'd0);
    check("req_busywait", {31'd0, busywait}, 32'd1);

    if (timed_out) exp_fm = 32'd0;
    else if (!wr)  exp_fm = rdata >> (8 * off);
    else           exp_fm = model_from_mem;
    exp_q.push_back(exp_fm);
    exp_busy = timed_out ? TIMEOUT + 1 : ack_at + 1;
    exp_req  = timed_out ? TIMEOUT : ack_at;

    busy_cnt = 1;
    req_cnt  = 0;
    done     = 1'b0;
    for (int cyc = 1; cyc <= TIMEOUT + 3; cyc++) begin
      next_cycle();
      mem_ack   = (cyc == ack_at);
      mem_rdata = (cyc == ack_at) ? rdata : $urandom;
      #2;
      if (!busywait) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      if (mem_req) req_cnt++;
      check("acc_mem_addr", mem_addr, a & ~32'h3);
      check("acc_mem_we", {31'd0, mem_we}, {31'd0, wr});
      check("acc_byteen", {28'd0, mem_byteen}, {28'd0, model_byteen(wr, sz, off)});
      if (wr) check("acc_wdata", mem_wdata, model_wdata(wd, sz));
    end
    check("done_reached", {31'd0, done}, 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    check("req_cycles", 32'(req_cnt), 32'(exp_req));
    check("done_mem_req", {31'd0, mem_req}, 32'd0);
    check("done_state", {30'd0, dbg_state}, 32'd2);
    check("done_bus_err", {31'd0, bus_err}, {31'd0, timed_out});
    if (exp_q.size() > 0) begin
      exp_fm = exp_q.pop_front();
      check("done_fromMem", fromMem, exp_fm);
      model_from_mem = exp_fm;
    end
  endtask

  task automatic reset_mid_access();
    next_cycle();
    memRead  = 1'b1;
    memWrite = 1'b0;
    funct3   = 3'b010;
    addr     = 32'h300;
    mem_ack  = 1'b0;
    #2;
    check("rst_req_busy", {31'd0, busywait}, 32'd1);
    next_cycle();
    #2;
    check("rst_access1", {31'd0, mem_req}, 32'd1);
    next_cycle();
    RESET = 1'b1;
    #2;
    check("rst_access2", {31'd0, mem_req}, 32'd1);
    next_cycle();
    RESET     = 1'b0;
    memRead   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
    #2;
    model_from_mem = 32'd0;
    check("rst_idle_state", {30'd0, dbg_state}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_fromMem", fromMem, 32'd0);
    next_cycle();
    mem_ack = 1'b0;
    #2;
    check("late_ack_fromMem", fromMem, model_from_mem);
    check("late_ack_state", {30'd0, dbg_state}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks         = 0;
    errors         = 0;
    model_from_mem = 32'd0;
    RESET          = 1'b1;
    addr           = '0;
    writeData      = '0;
    funct3         = '0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    mem_rdata      = '0;
    mem_ack        = 1'b0;
    repeat (2) next_cycle();
    #2;
    check("reset_busywait", {31'd0, busywait}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_fromMem", fromMem, 32'd0);
    check("reset_bus_err", {31'd0, bus_err}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_byteen", {28'd0, mem_byteen}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    next_cycle();
    RESET = 1'b0;

    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    idle_cycle(1'b0);
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0);
    do_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 2, 32'h11223344);
    do_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h0);
    do_access(1'b0, 1'b1, 3'b010, 32'h102, 32'h12345678, 1, 32'h0);
    idle_cycle(1'b0);
    do_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'h0);
    idle_cycle(1'b1);
    do_access(1'b1, 1'b0, 3'b000, 32'h41, 32'h0, 1, 32'hCAFEF00D);
    reset_mid_access();
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h0BADC0DE);
    do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 2, 32'h0);
    do_access(1'b1, 1'b1, 3'b001, 32'h22, 32'h00005A5A, 1, 32'hFFFFFFFF);

    for (int n = 0; n < 150; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      do_access(mode != 1, mode != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(1, TIMEOUT + 2), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
